// File: rtl/adc_frame_packer_if.sv
// Beat stream from the ADC frame packer toward the packet builder.
// The packer drives the master side and the consumer drives the slave side.
interface adc_frame_packer_if #(
  parameter int OUT_W = 32
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;

  modport master (output out_data, output out_valid, output out_first, input out_ready);
  modport slave  (input out_data, input out_valid, input out_first, output out_ready);
endinterface

// File: rtl/adc_frame_packer.sv
// Captures decimated frames of NCH DDR ADC words into a DEPTH-frame buffer
// and serialises each buffered frame into OUT_W-bit beats on a valid/ready stream.
module adc_frame_packer #(
  parameter int NCH   = 4,
  parameter int OUT_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH*16-1:0]        adc_data,
  input  logic                     enable,
  input  logic                     swap_edges,
  input  logic [7:0]               decim,
  adc_frame_packer_if.master       out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         overflow_count
);

  localparam int FW  = NCH * 16;
  localparam int BPF = FW / OUT_W;
  localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;

  logic [7:0]    dc;
  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [BW-1:0] beat;
  logic [FW-1:0] frame_in;
  logic [FW-1:0] frame_out;
  logic          tick;
  logic          full;
  logic          push;
  logic          drop;
  logic          valid;
  logic          xfer;
  logic          last_beat;
  logic          pop;

  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NCH; k++) begin
      frame_in[k*16+:16] = swap_edges ? {adc_data[k*16+:8], adc_data[k*16+8+:8]}
                                      : adc_data[k*16+:16];
    end
  end

  // Fullness uses the registered level, so a same-cycle pop never frees a slot for the tick.
  assign tick      = enable && (dc == 8'd0);
  assign full      = (level == LW'(DEPTH));
  assign push      = tick && !full;
  assign drop      = tick && full;
  assign valid     = (level != '0);
  assign xfer      = valid && out.out_ready;
  assign last_beat = (beat == BW'(BPF - 1));
  assign pop       = xfer && last_beat;

  assign frame_out     = mem[rd_ptr];
  assign out.out_valid = valid;
  assign out.out_first = valid && (beat == '0);
  assign out.out_data  = valid ? frame_out[beat*OUT_W+:OUT_W] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= frame_in;
    end
  end

  // Lowering decim below dc lets dc run on and wrap naturally at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc <= '0;
    end else if (!enable) begin
      dc <= '0;
    end else if (dc == decim) begin
      dc <= '0;
    end else begin
      dc <= dc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      beat           <= '0;
      level          <= '0;
      overflow_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) begin
        if (last_beat) begin
          beat   <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (drop && (overflow_count != {CNT_W{1'b1}})) begin
        overflow_count <= overflow_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: a cycle model queues expected beats on
// each capture tick and compares them as the DUT presents them.
module tb_adc_frame_packer;

  localparam int NCH   = 4;
  localparam int OUT_W = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int BPF   = NCH * 16 / OUT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             first;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NCH*16-1:0]      adc_data;
  logic                   enable;
  logic                   swap_edges;
  logic [7:0]             decim;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       overflow_count;

  logic [NCH*16-1:0] fixed_data;
  logic              rand_data;
  logic              rand_ready;
  logic              fixed_ready;
  logic              mon_on;

  int n_compared   = 0;
  int n_mismatched = 0;

  beat_t sb[$];
  int    mlevel;
  int    movf;
  int    mdc;
  int    mbeat;
  int    beat_cnt;
  int    frame_cnt;
  int    push_cnt;

  adc_frame_packer_if #(.OUT_W(OUT_W)) bus ();

  adc_frame_packer #(
    .NCH(NCH), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adc_data(adc_data),
    .enable(enable),
    .swap_edges(swap_edges),
    .decim(decim),
    .out(bus),
    .level(level),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change 2 time units after each rising edge, well clear of both edges.
  always @(posedge clk) begin
    #2;
    adc_data = rand_data ? {$urandom, $urandom} : fixed_data;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Compare what the DUT shows now, then advance the model to the next rising edge.
  always @(negedge clk) begin
    if (mon_on) begin
      logic             tick;
      logic             xfer;
      logic [NCH*16-1:0] frm;
      checkOutput("level", 64'(level), 64'(mlevel));
      checkOutput("overflow", 64'(overflow_count), 64'(movf));
      checkOutput("valid", 64'(bus.out_valid), 64'(mlevel != 0));
      if (bus.out_valid && sb.size() != 0) begin
        checkOutput("beat_data", 64'(bus.out_data), 64'(sb[0].data));
        checkOutput("beat_first", 64'(bus.out_first), 64'(sb[0].first));
      end
      if (reset) begin
        sb.delete();
        mlevel = 0;
        movf   = 0;
        mdc    = 0;
        mbeat  = 0;
      end else begin
        tick = enable && (mdc == 0);
        xfer = (mlevel != 0) && bus.out_ready;
        if (tick) begin
          if (mlevel < DEPTH) begin
            for (int k = 0; k < NCH; k++) begin
              frm[k*16+:16] = swap_edges ? {adc_data[k*16+:8], adc_data[k*16+8+:8]}
                                         : adc_data[k*16+:16];
            end
            for (int b = 0; b < BPF; b++) begin
              sb.push_back('{data: frm[b*OUT_W+:OUT_W], first: (b == 0)});
            end
            mlevel++;
            push_cnt++;
          end else if (movf < CMAX) begin
            movf++;
          end
        end
        if (xfer) begin
          beat_cnt++;
          if (sb.size() != 0) begin
            if (sb[0].first) frame_cnt++;
            void'(sb.pop_front());
          end
          if (mbeat == BPF - 1) begin
            mbeat = 0;
            mlevel--;
          end else begin
            mbeat++;
          end
        end
        if (!enable)           mdc = 0;
        else if (mdc == decim) mdc = 0;
        else                   mdc = (mdc + 1) % 256;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic swp, input logic [7:0] dec, input logic rdy);
    enable      = en;
    swap_edges  = swp;
    decim       = dec;
    fixed_ready = rdy;
  endtask

  task automatic doReset();
    reset  = 1'b1;
    enable = 1'b0;
    waitCycles(2);
    reset     = 1'b0;
    beat_cnt  = 0;
    frame_cnt = 0;
    push_cnt  = 0;
  endtask

  // Leaves the caller on the falling edge where a first beat is showing.
  task automatic waitFirst(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_first) seen = 1'b1;
    end
    if (!seen) checkOutput(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    adc_data      = '0;
    fixed_data    = '0;
    rand_data     = 1'b0;
    rand_ready    = 1'b0;
    mon_on        = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    mlevel = 0; movf = 0; mdc = 0; mbeat = 0;
    beat_cnt = 0; frame_cnt = 0; push_cnt = 0;
    waitCycles(2);
    mon_on = 1'b1;
    doReset();

    @(negedge clk);
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_first", 64'(bus.out_first), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_ovf", 64'(overflow_count), 64'd0);
    @(posedge clk); #1;

    // Fixed channel pattern, capture every cycle.
    fixed_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    waitFirst("t1_wait");
    checkOutput("t1_beat0", 64'(bus.out_data), 64'h22221111);
    @(negedge clk);
    checkOutput("t1_beat1", 64'(bus.out_data), 64'h44443333);
    checkOutput("t1_first1", 64'(bus.out_first), 64'd0);
    @(posedge clk); #1;
    waitCycles(10);

    // Per-channel byte swap.
    doReset();
    fixed_data = {48'h0, 16'h12AB};
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b1);
    waitFirst("t2_wait_sw");
    checkOutput("t2_swapped", 64'(bus.out_data[15:0]), 64'hAB12);
    @(posedge clk); #1;
    doReset();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    waitFirst("t2_wait_ns");
    checkOutput("t2_straight", 64'(bus.out_data[15:0]), 64'h12AB);
    @(posedge clk); #1;

    // decim=3 for 100 enabled cycles.
    doReset();
    rand_data = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b1);
    waitCycles(100);
    enable = 1'b0;
    waitCycles(10);
    checkOutput("t3_frames", 64'(frame_cnt), 64'd25);
    checkOutput("t3_beats", 64'(beat_cnt), 64'd50);
    checkOutput("t3_ovf", 64'(overflow_count), 64'd0);

    // Fill with the consumer stalled, then drain.
    doReset();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    waitCycles(20);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t4_full_level", 64'(level), 64'd8);
    checkOutput("t4_ovf", 64'(overflow_count), 64'd12);
    @(posedge clk); #1;
    fixed_ready = 1'b1;
    waitCycles(20);
    checkOutput("t4_drained", 64'(level), 64'd0);
    checkOutput("t4_beats", 64'(beat_cnt), 64'd16);

    // Random back-pressure.
    doReset();
    rand_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
    waitCycles(200);
    enable     = 1'b0;
    rand_ready = 1'b0;
    waitCycles(40);
    checkOutput("t5_level", 64'(level), 64'd0);
    checkOutput("t5_sb_left", 64'(sb.size()), 64'd0);
    checkOutput("t5_beats", 64'(beat_cnt), 64'(BPF * push_cnt));

    // Counter saturation, then reset in the middle of a frame.
    doReset();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    waitCycles(48);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t6_sat", 64'(overflow_count), 64'd15);
    @(posedge clk); #1;
    fixed_ready = 1'b1;
    waitCycles(1);
    fixed_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t6_rst_level", 64'(level), 64'd0);
    checkOutput("t6_rst_ovf", 64'(overflow_count), 64'd0);
    checkOutput("t6_rst_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    waitCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
